// File: rtl/neuron_potential_feeder_pkg.sv
// Shared definitions for the neuron potential feeder: FSM encoding, FP field
// bounds and the exponent-decay helper used when a new timestep starts.
package neuron_potential_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECAY   = 3'd1,
        ACCUM   = 3'd2,
        SETUP   = 3'd3,
        EVAL    = 3'd4,
        CAPTURE = 3'd5
    } state_t;

    localparam int          EVAL_SETTLE = 2;
    localparam logic [31:0] FP_ZERO     = 32'h00000000;
    localparam int          EXP_MSB     = 30;
    localparam int          EXP_LSB     = 23;
    localparam logic [7:0]  EXP_MAX     = 8'hFF;

    // Multiply by 2^-shift by lowering the exponent; underflow flushes to +0
    // and Inf/NaN pass through untouched.
    function automatic logic [31:0] fp_decay(input logic [31:0] value, input logic [2:0] shift);
        logic [7:0] exp_f;
        exp_f = value[EXP_MSB:EXP_LSB];
        if (exp_f == EXP_MAX) begin
            fp_decay = value;
        end else if (exp_f <= {5'd0, shift}) begin
            fp_decay = FP_ZERO;
        end else begin
            fp_decay = {value[31], exp_f - {5'd0, shift}, value[22:0]};
        end
    endfunction

endpackage

// File: rtl/neuron_potential_feeder_addsub.sv
// Combinational IEEE-754 single-precision adder/subtractor with
// round-to-nearest-even; subnormal operands are treated as zero.
module Addition_Subtraction
    import neuron_potential_feeder_pkg::*;
(
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        sub,
    output logic [31:0] result
);

    logic              sign_a_s, sign_b_s, a_big_s, sign_big_s, eff_add_s;
    logic [7:0]        exp_a_s, exp_b_s, exp_big_s, exp_small_s, exp_diff_s;
    logic [23:0]       man_big_s, man_small_s;
    logic [26:0]       big_ext_s, small_ext_s, aligned_s, lost_mask_s, diff_s, norm_s;
    logic [27:0]       sum_s;
    logic [24:0]       rounded_s;
    logic [4:0]        lz_s;
    logic              found_s, round_up_s;
    logic signed [9:0] exp_res_s;

    // Align, add or subtract magnitudes, normalise, round and pack.
    always_comb begin
        sign_a_s    = a_operand[31];
        sign_b_s    = b_operand[31] ^ sub;
        exp_a_s     = a_operand[EXP_MSB:EXP_LSB];
        exp_b_s     = b_operand[EXP_MSB:EXP_LSB];
        eff_add_s   = (sign_a_s == sign_b_s);
        a_big_s     = (a_operand[30:0] >= b_operand[30:0]);
        lost_mask_s = 27'd0;
        sum_s       = 28'd0;
        diff_s      = 27'd0;
        norm_s      = 27'd0;
        if (a_big_s) begin
            sign_big_s  = sign_a_s;
            exp_big_s   = exp_a_s;
            exp_small_s = exp_b_s;
            man_big_s   = {1'b1, a_operand[22:0]};
            man_small_s = {1'b1, b_operand[22:0]};
        end else begin
            sign_big_s  = sign_b_s;
            exp_big_s   = exp_b_s;
            exp_small_s = exp_a_s;
            man_big_s   = {1'b1, b_operand[22:0]};
            man_small_s = {1'b1, a_operand[22:0]};
        end
        exp_diff_s  = exp_big_s - exp_small_s;
        big_ext_s   = {man_big_s, 3'b000};
        small_ext_s = {man_small_s, 3'b000};
        // Bits shifted out of the smaller operand collapse into the sticky bit.
        if (exp_diff_s > 8'd26) begin
            aligned_s = {26'd0, |man_small_s};
        end else begin
            lost_mask_s = ~({27{1'b1}} << exp_diff_s[4:0]);
            aligned_s   = (small_ext_s >> exp_diff_s[4:0]) | {26'd0, |(small_ext_s & lost_mask_s)};
        end
        exp_res_s = signed'({2'b00, exp_big_s});
        if (eff_add_s) begin
            sum_s = {1'b0, big_ext_s} + {1'b0, aligned_s};
            if (sum_s[27]) begin
                norm_s    = sum_s[27:1] | {26'd0, sum_s[0]};
                exp_res_s = exp_res_s + 10'sd1;
            end else begin
                norm_s = sum_s[26:0];
            end
        end else begin
            diff_s = big_ext_s - aligned_s;
        end
        lz_s    = 5'd0;
        found_s = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found_s && !diff_s[i]) begin
                lz_s = lz_s + 5'd1;
            end else begin
                found_s = 1'b1;
            end
        end
        if (!eff_add_s) begin
            norm_s    = diff_s << lz_s;
            exp_res_s = exp_res_s - signed'({5'd0, lz_s});
        end else begin
            norm_s = norm_s;
        end
        round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        rounded_s  = {1'b0, norm_s[26:3]} + {24'd0, round_up_s};
        if (rounded_s[24]) begin
            rounded_s = rounded_s >> 1;
            exp_res_s = exp_res_s + 10'sd1;
        end else begin
            rounded_s = rounded_s;
        end
        if (exp_a_s == EXP_MAX) begin
            result = a_operand;
        end else if (exp_b_s == EXP_MAX) begin
            result = {sign_b_s, b_operand[30:0]};
        end else if (exp_a_s == 8'd0) begin
            result = {sign_b_s, b_operand[30:0]};
        end else if (exp_b_s == 8'd0) begin
            result = a_operand;
        end else if (!eff_add_s && (diff_s == 27'd0)) begin
            result = FP_ZERO;
        end else if (exp_res_s >= 10'sd255) begin
            result = {sign_big_s, EXP_MAX, 23'd0};
        end else if (exp_res_s <= 10'sd0) begin
            result = {sign_big_s, 31'd0};
        end else begin
            result = {sign_big_s, exp_res_s[7:0], rounded_s[22:0]};
        end
    end

endmodule

// File: rtl/neuron_potential_feeder.sv
// Sequences one neuron timestep: decay the membrane potential, accumulate the
// synaptic weights, drive the external potential adder and capture its result.
module neuron_potential_feeder
    import neuron_potential_feeder_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        timestep_start,
    input  logic        weight_valid,
    output logic        weight_ready,
    input  logic [31:0] weight_in,
    input  logic        weight_last,
    input  logic [2:0]  decay_shift,
    output logic        set_adder,
    output logic        clear_adder,
    output logic [31:0] input_weight,
    output logic [31:0] decayed_potential,
    input  logic [31:0] final_potential,
    input  logic        spike,
    output logic [31:0] potential_out,
    output logic        spike_out,
    output logic        out_valid,
    output logic        done
);

    localparam logic [1:0] SETTLE_LAST = 2'(EVAL_SETTLE - 1);

    state_t      state_r;
    logic [31:0] pot_r;
    logic [31:0] acc_r;
    logic [1:0]  settle_r;
    logic [31:0] acc_sum_s;

    Addition_Subtraction u_acc_add (
        .a_operand (acc_r),
        .b_operand (weight_in),
        .sub       (1'b0),
        .result    (acc_sum_s)
    );

    assign input_weight      = acc_r;
    assign decayed_potential = pot_r;

    // Timestep FSM; outputs are registered to match the state being entered.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r       <= IDLE;
            pot_r         <= FP_ZERO;
            acc_r         <= FP_ZERO;
            settle_r      <= 2'd0;
            potential_out <= FP_ZERO;
            spike_out     <= 1'b0;
            out_valid     <= 1'b0;
            done          <= 1'b0;
            weight_ready  <= 1'b0;
            set_adder     <= 1'b0;
            clear_adder   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (timestep_start) begin
                        state_r <= DECAY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DECAY: begin
                    pot_r        <= fp_decay(pot_r, decay_shift);
                    acc_r        <= FP_ZERO;
                    weight_ready <= 1'b1;
                    state_r      <= ACCUM;
                end
                ACCUM: begin
                    if (weight_valid && weight_ready) begin
                        acc_r <= acc_sum_s;
                        if (weight_last) begin
                            weight_ready <= 1'b0;
                            clear_adder  <= 1'b0;
                            set_adder    <= 1'b1;
                            state_r      <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    set_adder <= 1'b0;
                    settle_r  <= 2'd0;
                    state_r   <= EVAL;
                end
                EVAL: begin
                    if (settle_r == SETTLE_LAST) begin
                        pot_r         <= final_potential;
                        potential_out <= final_potential;
                        spike_out     <= spike;
                        out_valid     <= 1'b1;
                        done          <= 1'b1;
                        state_r       <= CAPTURE;
                    end else begin
                        settle_r <= settle_r + 2'd1;
                    end
                end
                CAPTURE: begin
                    out_valid   <= 1'b0;
                    done        <= 1'b0;
                    clear_adder <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    out_valid    <= 1'b0;
                    done         <= 1'b0;
                    weight_ready <= 1'b0;
                    set_adder    <= 1'b0;
                    clear_adder  <= 1'b1;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_potential_feeder.sv
// Randomised bench for neuron_potential_feeder: weights are small integers so
// the expected FP sums are exact, and the bench plays the potential adder.
module tb_neuron_potential_feeder;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        timestep_start;
    logic        weight_valid;
    logic        weight_ready;
    logic [31:0] weight_in;
    logic        weight_last;
    logic [2:0]  decay_shift;
    logic        set_adder;
    logic        clear_adder;
    logic [31:0] input_weight;
    logic [31:0] decayed_potential;
    logic [31:0] final_potential;
    logic        spike;
    logic [31:0] potential_out;
    logic        spike_out;
    logic        out_valid;
    logic        done;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_pot, model_out;
    logic        model_spk;
    int          wq[$];

    neuron_potential_feeder dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .timestep_start    (timestep_start),
        .weight_valid      (weight_valid),
        .weight_ready      (weight_ready),
        .weight_in         (weight_in),
        .weight_last       (weight_last),
        .decay_shift       (decay_shift),
        .set_adder         (set_adder),
        .clear_adder       (clear_adder),
        .input_weight      (input_weight),
        .decayed_potential (decayed_potential),
        .final_potential   (final_potential),
        .spike             (spike),
        .potential_out     (potential_out),
        .spike_out         (spike_out),
        .out_valid         (out_valid),
        .done              (done)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, expv);
        end
    endtask

    // Exact float encoding of a small integer.
    function automatic logic [31:0] int_to_fp(input int v);
        int          mag, p;
        logic [31:0] r;
        if (v == 0) return 32'h00000000;
        mag = (v < 0) ? -v : v;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((mag << (23 - p)) & 32'h007FFFFF);
        return r;
    endfunction

    // Value halved 'sh' times; flushes to +0 once the exponent would reach 0.
    function automatic logic [31:0] model_decay(input logic [31:0] v, input int sh);
        int e;
        e = int'(v[30:23]);
        if (e == 255) return v;
        if (e - sh < 1) return 32'h00000000;
        return {v[31], 8'(e - sh), v[22:0]};
    endfunction

    task automatic run_ts(input int sh, input logic [31:0] fin, input logic spk,
                          input int gmin, input int gmax, input bit poke);
        int          sum, lat, gap;
        logic [31:0] exp_dec;
        exp_dec = model_decay(model_pot, sh);
        decay_shift     = 3'(sh);
        final_potential = fin;
        spike           = spk;
        timestep_start  = 1'b1;
        @(posedge CLK); #1;
        timestep_start = 1'b0;
        check_val("decay_wready", weight_ready, 32'd0);
        @(posedge CLK); #1;
        check_val("decayed", decayed_potential, exp_dec);
        check_val("acc_cleared", input_weight, 32'h00000000);
        check_val("accum_wready", weight_ready, 32'd1);
        check_val("pot_out_hold", potential_out, model_out);
        check_val("spike_out_hold", spike_out, 32'(model_spk));
        model_pot = exp_dec;
        sum = 0;
        foreach (wq[i]) begin
            gap = $urandom_range(gmin, gmax);
            for (int g = 0; g < gap; g++) begin
                if (poke) timestep_start = 1'b1;
                weight_in = $urandom;
                @(posedge CLK); #1;
                timestep_start = 1'b0;
                check_val("gap_acc", input_weight, int_to_fp(sum));
            end
            weight_valid = 1'b1;
            weight_in    = int_to_fp(wq[i]);
            weight_last  = (i == wq.size() - 1);
            @(posedge CLK); #1;
            weight_valid = 1'b0;
            weight_last  = 1'b0;
            weight_in    = $urandom;
            sum += wq[i];
            check_val("acc_sum", input_weight, int_to_fp(sum));
        end
        check_val("setup_set", set_adder, 32'd1);
        check_val("setup_clear", clear_adder, 32'd0);
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge CLK); #1;
            lat++;
            if (lat == 2) check_val("eval_set", set_adder, 32'd0);
        end
        check_val("latency", 32'(lat), 32'd4);
        check_val("done", done, 32'd1);
        check_val("pot_out", potential_out, fin);
        check_val("spike_out", spike_out, 32'(spk));
        check_val("pot_reg", decayed_potential, fin);
        model_pot = fin;
        model_out = fin;
        model_spk = spk;
        @(posedge CLK); #1;
        check_val("valid_drop", out_valid, 32'd0);
        check_val("idle_clear", clear_adder, 32'd1);
        if (poke) begin
            repeat (3) begin
                @(posedge CLK); #1;
                check_val("no_requeue", weight_ready, 32'd0);
            end
        end
    endtask

    initial begin
        bit saw_valid;
        RESET_N        = 1'b0;
        timestep_start = 1'b0;
        weight_valid   = 1'b0;
        weight_in      = 32'h0;
        weight_last    = 1'b0;
        decay_shift    = 3'd0;
        final_potential = 32'h0;
        spike          = 1'b0;
        model_pot = 32'h0;
        model_out = 32'h0;
        model_spk = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_clear", clear_adder, 32'd1);
        check_val("rst_set", set_adder, 32'd0);
        check_val("rst_wready", weight_ready, 32'd0);
        check_val("rst_valid", out_valid, 32'd0);
        check_val("rst_done", done, 32'd0);
        check_val("rst_spike", spike_out, 32'd0);
        check_val("rst_pot_out", potential_out, 32'h0);
        check_val("rst_decayed", decayed_potential, 32'h0);
        check_val("rst_inw", input_weight, 32'h0);
        RESET_N = 1'b1;
        @(posedge CLK); #1;

        wq = '{0};        run_ts(0, 32'h42200000, 1'b0, 0, 0, 1'b0);
        wq = '{1, 2};     run_ts(1, 32'h3F800000, 1'b0, 0, 0, 1'b0);
        wq = '{3, -5, 4}; run_ts(7, 32'h02800000, 1'b0, 0, 1, 1'b0);
        wq = '{-2};       run_ts(5, 32'h7F800000, 1'b0, 0, 0, 1'b0);
        wq = '{7, -7};    run_ts(3, 32'h40000000, 1'b1, 0, 0, 1'b0);
        wq = '{2, 5, -1}; run_ts(0, int_to_fp(-12), 1'b0, 3, 3, 1'b1);

        // Reset asserted while the adder is settling.
        wq = '{};
        decay_shift    = 3'd1;
        timestep_start = 1'b1;
        @(posedge CLK); #1;
        timestep_start = 1'b0;
        @(posedge CLK); #1;
        weight_valid = 1'b1;
        weight_in    = int_to_fp(6);
        weight_last  = 1'b1;
        @(posedge CLK); #1;
        weight_valid = 1'b0;
        weight_last  = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        #1;
        check_val("mid_rst_pot", decayed_potential, 32'h0);
        check_val("mid_rst_inw", input_weight, 32'h0);
        check_val("mid_rst_clear", clear_adder, 32'd1);
        check_val("mid_rst_valid", out_valid, 32'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge CLK); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check_val("mid_rst_no_valid", 32'(saw_valid), 32'd0);
        model_pot = 32'h0;
        model_out = 32'h0;
        model_spk = 1'b0;

        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(1, 5);
            wq = '{};
            for (int k = 0; k < n; k++) wq.push_back(int'($urandom_range(0, 16)) - 8);
            run_ts(int'($urandom_range(0, 7)), int_to_fp(int'($urandom_range(0, 200)) - 100),
                   1'($urandom_range(0, 1)), 0, 2, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_potential_feeder.md
NEURON_POTENTIAL_FEEDER -- requirements
Module: neuron_potential_feeder

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port timestep_start, input, 1, single-cycle pulse that starts a timestep.
REQ-004 SHALL have ports weight_valid (input, 1), weight_ready (output, 1) and weight_in (input, 32, IEEE-754 single) forming the synaptic weight handshake.
REQ-005 SHALL have port weight_last, input, 1, qualified by weight_valid, marking the last weight of the timestep.
REQ-006 SHALL have port decay_shift, input, 3, exponent decrement per timestep (decay by 2^-decay_shift).
REQ-007 SHALL have ports set_adder and clear_adder (outputs, 1), driving the potential adder's set/clear controls.
REQ-008 SHALL have ports input_weight and decayed_potential (outputs, 32), driving the adder operands.
REQ-009 SHALL have ports final_potential (input, 32) and spike (input, 1), the adder results.
REQ-010 SHALL have ports potential_out (output, 32), spike_out (output, 1), out_valid (output, 1) and done (output, 1).

Function
REQ-011 FSM states SHALL be IDLE, DECAY, ACCUM, SETUP, EVAL, CAPTURE.
REQ-012 IDLE: clear_adder=1, set_adder=0, weight_ready=0; timestep_start moves to DECAY.
REQ-013 DECAY (1 cycle) SHALL replace the potential register: exp==255 leaves it unchanged; exp<=decay_shift gives +0; otherwise exp-=decay_shift, sign and mantissa kept. It SHALL clear the weight accumulator to +0, then go to ACCUM.
REQ-014 ACCUM: weight_ready=1; each weight_valid&&weight_ready cycle sets accumulator = accumulator + weight_in (FP add); a handshake with weight_last=1 moves to SETUP.
REQ-015 SHALL tolerate weight_valid low for any number of cycles in ACCUM without changing state or accumulator.
REQ-016 A timestep with no synaptic input SHALL be signalled by the source as one weight 0x00000000 with weight_last=1.
REQ-017 SETUP (1 cycle): clear_adder=0, set_adder=1.
REQ-018 EVAL: clear_adder=0, set_adder=0, held exactly 2 cycles (settle count), then CAPTURE.
REQ-019 input_weight SHALL equal the accumulator and decayed_potential SHALL equal the potential register at all times.
REQ-020 CAPTURE (1 cycle): latch final_potential into the potential register, potential_out and spike_out; pulse out_valid=1 and done=1; return to IDLE.
REQ-021 Latency from the weight_last handshake to out_valid SHALL be 4 cycles (SETUP + 2 EVAL + CAPTURE).
REQ-022 timestep_start outside IDLE SHALL be ignored (no queuing).
REQ-023 out_valid and done SHALL be high only in CAPTURE; spike_out and potential_out SHALL hold until the next CAPTURE.

Reset
REQ-024 RESET_N low SHALL asynchronously force IDLE; potential register, accumulator, potential_out, decayed_potential and input_weight = 0x00000000; spike_out, out_valid, done, weight_ready, set_adder = 0; clear_adder = 1.
REQ-025 Reset in any state mid-timestep SHALL discard the partial accumulation, and no out_valid SHALL follow.

Structure
REQ-026 A shared package SHALL hold the state encoding, EVAL_SETTLE=2, FP_ZERO=32'h00000000 and the exponent field bounds (bits 30:23).
REQ-027 The FP accumulation SHALL use the team's existing Addition_Subtraction sub-module (operation=add); the exponent decay SHALL be inline logic.

Verification
REQ-028 Reset then idle -> clear_adder=1, all outputs zero, weight_ready=0.
REQ-029 Potential 0x42200000 (40.0), decay_shift=1, weights 0x3F800000 and 0x40000000 (last) -> decayed_potential=0x41A00000 (20.0), input_weight=0x40400000 (3.0), out_valid exactly 4 cycles after the last handshake.
REQ-030 Potential 0x3F800000 (exp 127), decay_shift=7 -> 0x3C000000; with potential exp=5 and decay_shift=5 -> 0x00000000.
REQ-031 weight_valid gaps of 3 cycles between weights and timestep_start pulsed during ACCUM -> sums unchanged, no second timestep started.
REQ-032 Adder model returns spike=1 and final_potential=0x40000000 -> spike_out=1, potential_out=0x40000000, next DECAY starts from 0x40000000.
REQ-033 RESET_N low during EVAL -> immediate IDLE, potential register 0, no out_valid.
